// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and defaults for the successive-approximation search controller
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } sar_state_t;

    localparam int SAR_WIDTH_DEF = 4;

endpackage

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search controller, MSB first; option macro SAR_EARLY_EXIT_EN
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    IDX_TOP   = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ONE   = IW'(1);

    sar_state_t        state;
    logic [IW-1:0]     idx;
    logic              keep;
    logic [WIDTH-1:0]  resolved;
    logic [WIDTH-1:0]  next_trial;

    // Resolve the bit under test from the comparator verdict and arm the next lower bit
    always_comb begin
        keep       = cmp_gt | cmp_eq;
        resolved   = trial;
        if (!keep) begin
            resolved[idx] = 1'b0;
        end
        next_trial = resolved;
        if (idx != '0) begin
            next_trial[idx - IDX_ONE] = 1'b1;
        end
    end

    // Search state machine; all outputs are registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            trial  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    trial <= '0;
                    state <= IDLE;
                    if (start) begin
                        trial <= TRIAL_MSB;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= TRIAL;
                    end
                end
                TRIAL: begin
`ifdef SAR_EARLY_EXIT_EN
                    if (cmp_eq) begin
                        // Exact hit: the current trial already is the answer
                        result <= trial;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (idx == '0) begin
`else
                    if (idx == '0) begin
`endif
                        result <= resolved;
                        trial  <= resolved;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        trial <= next_trial;
                        idx   <= idx - IDX_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    trial <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - directed bench for sar_search with a behavioural comparator closing the loop
module tb_sar_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cmp_gt;
    logic       cmp_eq;
    logic [3:0] trial;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [3:0] unknown;

    int n_checks;
    int n_fail;

    logic [3:0] trace [0:15];

    sar_search #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    assign cmp_gt = (unknown > trial);
    assign cmp_eq = (unknown == trial);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a search at a negedge, optionally re-pulse start at cycle restart_at,
    // record the trial seen after each edge, and return the edge count to done.
    task automatic run_search(input logic [3:0] u, input int restart_at, output int lat);
        unknown = u;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        trace[0] = trial;
        lat      = 0;
        while (!done && lat < 12) begin
            if (lat == restart_at) start = 1'b1;
            else                   start = 1'b0;
            @(negedge clk);
            lat++;
            if (lat < 16) trace[lat] = trial;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'(lat), 32'd4);
    endtask

    int lat;
    int first_done;
    int second_done;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        unknown  = 4'd7;
        repeat (2) @(negedge clk);
        check("rst_trial",  32'(trial),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_trial", 32'(trial), 32'd0);
        check("idle_busy",  32'(busy),  32'd0);

        // unknown=1011: trial walk 1000,1100,1010,1011
        run_search(4'b1011, -1, lat);
        check("b1011_t0",   32'(trace[0]), 32'b1000);
        check("b1011_busy", 32'(busy),     32'd0);
        check("b1011_t1",   32'(trace[1]), 32'b1100);
        check("b1011_t2",   32'(trace[2]), 32'b1010);
        check("b1011_t3",   32'(trace[3]), 32'b1011);
        check("b1011_lat",  32'(lat),      32'd4);
        check("b1011_res",  32'(result),   32'b1011);
        @(negedge clk);
        check("b1011_done_pulse", 32'(done),   32'd0);
        check("b1011_trial_clr",  32'(trial),  32'd0);
        check("b1011_res_hold",   32'(result), 32'b1011);

        // Boundaries of the code range
        run_search(4'd0, -1, lat);
        check("zero_lat", 32'(lat),    32'd4);
        check("zero_res", 32'(result), 32'd0);
        @(negedge clk);
        run_search(4'd15, -1, lat);
        check("max_lat", 32'(lat),    32'd4);
        check("max_res", 32'(result), 32'd15);
        @(negedge clk);

        // Hit on the very first trial
        run_search(4'd8, -1, lat);
`ifdef SAR_EARLY_EXIT_EN
        check("eight_lat", 32'(lat), 32'd1);
`else
        check("eight_lat", 32'(lat), 32'd4);
`endif
        check("eight_res", 32'(result), 32'b1000);
        @(negedge clk);

        // Start pulsed mid-search must not restart it
        run_search(4'b0101, 2, lat);
        check("restart_lat", 32'(lat),    32'd4);
        check("restart_res", 32'(result), 32'b0101);
        @(negedge clk);
        check("restart_idle", 32'(busy), 32'd0);

        // Reset during the third trial abandons the search
        unknown = 4'b0110;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_t3", 32'(trial), 32'b0110);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_trial",  32'(trial),  32'd0);
        check("rstmid_busy",   32'(busy),   32'd0);
        check("rstmid_result", 32'(result), 32'd0);
        first_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) first_done = 1;
        end
        check("rstmid_no_done", 32'(first_done), 32'd0);

        // Start held high: a new search launches from DONE, pulses every 5 cycles
        unknown     = 4'b1001;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0)       first_done  = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start = 1'b0;
        check("b2b_first",  32'(first_done),               32'd5);
        check("b2b_period", 32'(second_done - first_done), 32'd5);
        check("b2b_res",    32'(result),                   32'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
